// File: rtl/jcsa_pipe_adder_if.sv
// Operand/result handshake bundle for jcsa_pipe_adder; the overflow flag is
// present only when JCSA_OVF_EN is defined.
interface jcsa_pipe_adder_if #(
   parameter int WIDTH = 16,
   parameter int NBLK  = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             carryin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic             carryout;
   logic [NBLK-1:0]  skip;
`ifdef JCSA_OVF_EN
   logic             overflow;
`endif

   modport master (
      output in_valid, A, B, carryin, out_ready,
      input  in_ready, out_valid, Y, carryout, skip
`ifdef JCSA_OVF_EN
      , overflow
`endif
   );

   modport slave (
      input  in_valid, A, B, carryin, out_ready,
      output in_ready, out_valid, Y, carryout, skip
`ifdef JCSA_OVF_EN
      , overflow
`endif
   );
endinterface

// File: rtl/jcsa_pipe_adder.sv
// Carry-skip adder pipelined one BLOCK-bit slice per stage: latency NBLK, full
// throughput, whole pipe stalls when the output is held. JCSA_OVF_EN adds overflow.
module jcsa_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   jcsa_pipe_adder_if.slave io
);
   localparam int BLK_SAFE = (BLOCK < 1) ? 1 : BLOCK;
   localparam int NBLK     = WIDTH / BLK_SAFE;

   if ((BLOCK < 1) || ((WIDTH % BLK_SAFE) != 0)) begin : g_bad_cfg
      $error("jcsa_pipe_adder: WIDTH must be a positive multiple of BLOCK");
   end

   logic en;
   assign en          = !io.out_valid || io.out_ready;
   assign io.in_ready = en;

   // Stage k adds bits [HI-1:LO]; it keeps the finished low sum bits and only
   // the operand bits that later stages still need.
   for (genvar k = 0; k < NBLK; k++) begin : g_st
      localparam int LO = k * BLOCK;
      localparam int HI = LO + BLOCK;

      logic [WIDTH-LO-1:0] a_src, b_src;
      logic                c_src, v_src;
      logic [BLOCK-1:0]    prop, bsum;
      logic                rc, c_d;
      logic [HI-1:0]       sum_d, sum_q;
      logic [k:0]          skp_d, skp_q;
      logic                c_q, v_q;

      if (k == 0) begin : g_src
         assign a_src = io.A;
         assign b_src = io.B;
         assign c_src = io.carryin;
         assign v_src = io.in_valid;
         assign sum_d = bsum;
         assign skp_d = &prop;
      end else begin : g_src
         assign a_src = g_st[k-1].g_op.a_q;
         assign b_src = g_st[k-1].g_op.b_q;
         assign c_src = g_st[k-1].c_q;
         assign v_src = g_st[k-1].v_q;
         assign sum_d = {bsum, g_st[k-1].sum_q};
         assign skp_d = {&prop, g_st[k-1].skp_q};
      end

      assign prop = a_src[BLOCK-1:0] ^ b_src[BLOCK-1:0];

      always_comb begin : ripple
         logic c;
         c = c_src;
         for (int i = 0; i < BLOCK; i++) begin
            bsum[i] = prop[i] ^ c;
            c       = (a_src[i] & b_src[i]) | (prop[i] & c);
         end
         rc = c;
      end

      // Skip mux: an all-propagate block passes its carry-in straight through.
      assign c_d = (&prop) ? c_src : rc;

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
            skp_q <= '0;
         end else if (en) begin
            v_q   <= v_src;
            c_q   <= c_d;
            sum_q <= sum_d;
            skp_q <= skp_d;
         end
      end

      if (k < NBLK - 1) begin : g_op
         logic [WIDTH-HI-1:0] a_q, b_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= a_src[WIDTH-LO-1:BLOCK];
               b_q <= b_src[WIDTH-LO-1:BLOCK];
            end
         end
      end
   end

   assign io.out_valid = g_st[NBLK-1].v_q;
   assign io.Y         = g_st[NBLK-1].sum_q;
   assign io.carryout  = g_st[NBLK-1].c_q;
   assign io.skip      = g_st[NBLK-1].skp_q;

`ifdef JCSA_OVF_EN
   // Carry into the MSB is recovered as sum_msb ^ propagate_msb.
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (en)
         ovf_q <= g_st[NBLK-1].bsum[BLOCK-1] ^ g_st[NBLK-1].prop[BLOCK-1]
                  ^ g_st[NBLK-1].c_d;
   end
   assign io.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_jcsa_pipe_adder.sv
// Directed bench for jcsa_pipe_adder (WIDTH=16, BLOCK=4): hand vectors, streaming,
// stall and mid-flight reset; build with JCSA_OVF_EN to also check overflow.
module tb_jcsa_pipe_adder;
   localparam int WIDTH = 16;
   localparam int NBLK  = 4;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cyc;
   int   npop;
   int   first_pop;
   int   last_pop;
   int   npop0;
   logic [20:0] q[$];

   jcsa_pipe_adder_if #(.WIDTH(WIDTH), .NBLK(NBLK)) io ();

   jcsa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic c);
      logic [16:0] s;
      logic [3:0]  sk;
      s = 17'(a) + 17'(b) + 17'(c);
      for (int k = 0; k < 4; k++) sk[k] = &(a[k*4 +: 4] ^ b[k*4 +: 4]);
      return {s[16], sk, s[15:0]};
   endfunction

   // One clock with scoreboard bookkeeping of both handshakes.
   task automatic cycle();
      #1;
      if (io.in_valid && io.in_ready) q.push_back(model(io.A, io.B, io.carryin));
      if (io.out_valid && io.out_ready) begin
         if (q.size() == 0) begin
            chk("stale_out", 32'(io.out_valid), 32'd0);
         end else begin
            chk("stream", {11'b0, io.carryout, io.skip, io.Y}, {11'b0, q[0]});
            void'(q.pop_front());
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      io.A        = 16'($urandom);
      io.B        = 16'($urandom);
      io.carryin  = 1'($urandom);
      io.in_valid = 1'b1;
   endtask

   // Single transaction into an empty pipe; result left held at the output.
   task automatic dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] ey, input logic ec,
                      input logic [3:0] es);
      io.out_ready = 1'b0;
      io.A = a; io.B = b; io.carryin = c; io.in_valid = 1'b1;
      #1;
      chk({tag, "_inrdy"}, 32'(io.in_ready), 32'd1);
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      for (int j = 1; j < NBLK; j++) begin
         chk({tag, "_lat"}, 32'(io.out_valid), 32'd0);
         @(posedge clk); #1;
      end
      chk({tag, "_vld"}, 32'(io.out_valid), 32'd1);
      chk({tag, "_y"}, 32'(io.Y), 32'(ey));
      chk({tag, "_cout"}, 32'(io.carryout), 32'(ec));
      chk({tag, "_skip"}, 32'(io.skip), 32'(es));
      chk({tag, "_stall"}, 32'(io.in_ready), 32'd0);
   endtask

   task automatic drain(input string tag);
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_drain"}, 32'(io.out_valid), 32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; npop = 0;
      first_pop = -1; last_pop = -1;
      rst = 1'b1;
      io.in_valid = 1'b1; io.A = 16'h1111; io.B = 16'h2222; io.carryin = 1'b0;
      io.out_ready = 1'b1;

      // Reset with a live offer on the inputs: it must not be taken.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", 32'(io.out_valid), 32'd0);
      chk("rst_y", 32'(io.Y), 32'd0);
      chk("rst_skip", 32'(io.skip), 32'd0);
      chk("rst_cout", 32'(io.carryout), 32'd0);
      rst = 1'b0;
      io.in_valid = 1'b0;
      #1;
      chk("rst_inrdy", 32'(io.in_ready), 32'd1);
      repeat (6) cycle();

      dir("v0", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110);
      drain("v0");
      dir("v1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111);
      drain("v1");
      dir("v2", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);
`ifdef JCSA_OVF_EN
      chk("v2_ovf", 32'(io.overflow), 32'd0);
`endif
      drain("v2");
      dir("v3", 16'h0F0F, 16'h00F0, 1'b1, 16'h1000, 1'b0, 4'b0111);
      drain("v3");
      dir("v4", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b0000);
      drain("v4");
      dir("v5", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'b0110);
`ifdef JCSA_OVF_EN
      chk("v5_ovf", 32'(io.overflow), 32'd1);
`endif
      drain("v5");
      dir("v6", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000);
`ifdef JCSA_OVF_EN
      chk("v6_ovf", 32'(io.overflow), 32'd1);
`endif
      drain("v6");

      // Back-to-back stream of 8.
      io.out_ready = 1'b1;
      npop0 = npop; first_pop = -1; last_pop = -1;
      for (int i = 0; i < 8; i++) begin
         drive_rand();
         cycle();
      end
      io.in_valid = 1'b0;
      for (int j = 0; j < 12 && q.size() > 0; j++) cycle();
      chk("stream_cnt", 32'(npop - npop0), 32'd8);
      chk("stream_span", 32'(last_pop - first_pop), 32'd7);

      // Fill the pipe, then hold the output for 5 cycles.
      npop0 = npop;
      for (int i = 0; i < 6; i++) begin
         drive_rand();
         cycle();
      end
      io.out_ready = 1'b0;
      drive_rand();
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("stall_inrdy", 32'(io.in_ready), 32'd0);
         chk("stall_vld", 32'(io.out_valid), 32'd1);
         chk("stall_hold", {11'b0, io.carryout, io.skip, io.Y}, {11'b0, q[0]});
         cycle();
      end
      io.out_ready = 1'b1;
      io.in_valid = 1'b0;
      for (int j = 0; j < 12 && q.size() > 0; j++) cycle();
      chk("stall_cnt", 32'(npop - npop0), 32'd6);
      chk("stall_left", 32'(q.size()), 32'd0);

      // Reset with three results in flight.
      io.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_rand();
         cycle();
      end
      io.in_valid = 1'b0;
      cycle();
      chk("mr_pre", 32'(io.out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mr_vld", 32'(io.out_valid), 32'd0);
      chk("mr_y", 32'(io.Y), 32'd0);
      chk("mr_skip", 32'(io.skip), 32'd0);
      rst = 1'b0;
      q.delete();
      io.out_ready = 1'b1;
      #1;
      chk("mr_inrdy", 32'(io.in_ready), 32'd1);
      repeat (8) cycle();
      chk("mr_after", 32'(io.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/jcsa_pipe_adder.md
JCSA_PIPE_ADDER -- requirements
Module: jcsa_pipe_adder

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
- REQ-002 The block SHALL have parameter BLOCK, default 4: bits per carry-skip block; NBLK = WIDTH/BLOCK.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set offered.
- REQ-006 The block SHALL have port in_ready, output, 1 bit: operand set accepted this cycle when high with in_valid.
- REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: operands.
- REQ-008 The block SHALL have port carryin, input, 1 bit: carry into bit 0.
- REQ-009 The block SHALL have port out_valid, output, 1 bit: result present.
- REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
- REQ-011 The block SHALL have port Y, output, WIDTH bits: sum.
- REQ-012 The block SHALL have port carryout, output, 1 bit: carry out of bit WIDTH-1.
- REQ-013 The block SHALL have port skip, output, NBLK bits: bit k high when every propagate bit (A^B) of block k was 1.

Function
- REQ-014 The block SHALL be a pipeline of NBLK stages; stage k computes sum bits [k*BLOCK+BLOCK-1 : k*BLOCK] with ripple carry and a skip mux: block carry-out = carry-in when all block propagates are 1, else ripple carry-out.
- REQ-015 Each stage SHALL register its block sum, block carry-out, skip bit, valid bit, and the not-yet-consumed upper operand bits; lower sum bits SHALL be delayed alongside.
- REQ-016 Latency SHALL be exactly NBLK cycles from the accept edge (in_valid && in_ready) to the first cycle out_valid is high with that result, absent stalls.
- REQ-017 Throughput SHALL be one result per cycle when out_ready is held high.
- REQ-018 The pipeline advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
- REQ-019 When en is low, all stage registers including Y, carryout, skip and out_valid SHALL hold.
- REQ-020 Bubbles (in_valid low while en is high) SHALL propagate as invalid stages; registers with valid low may hold any data, but outputs SHALL only change when en is high.
- REQ-021 Y/carryout SHALL equal (A + B + carryin) truncated to WIDTH bits / bit WIDTH of that sum, for all operand values, including all-ones propagate chains across every block.
- REQ-022 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated under arbitrary out_ready patterns.
- REQ-023 WIDTH not divisible by BLOCK, or BLOCK < 1, SHALL cause an elaboration error; NBLK = 1 SHALL give latency 1.

Reset
- REQ-024 While rst is high at a clock edge, all valid bits SHALL clear; Y, carryout, skip and (when compiled) overflow SHALL become 0.
- REQ-025 Reset mid-operation SHALL discard every in-flight result; out_valid SHALL be low on the cycle after reset deasserts, and in_ready SHALL be high.
- REQ-026 Inputs presented during the reset cycle SHALL NOT be accepted.

Configuration
- REQ-027 Macro JCSA_OVF_EN defined: the block SHALL add output port overflow, 1 bit, registered with Y: signed two's-complement overflow = carry into MSB XOR carryout.
- REQ-028 Macro JCSA_OVF_EN undefined: port overflow and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=16, BLOCK=4, NBLK=4)
- REQ-029 A=0xFFFF, B=0x0001, cin=0, out_ready=1 -> after 4 cycles Y=0x0000, carryout=1, skip=4'b1110.
- REQ-030 A=0xFFFF, B=0x0000, cin=1 -> Y=0x0000, carryout=1, skip=4'b1111; A=0x1234, B=0x4321, cin=0 -> Y=0x5555, carryout=0, skip=4'b0000.
- REQ-031 Back-to-back 8 random sets with out_ready=1 -> 8 consecutive out_valid cycles, results matching the reference model in order.
- REQ-032 Fill pipe, drop out_ready for 5 cycles -> in_ready=0 and Y/out_valid stable throughout; on release, results resume in order with none lost.
- REQ-033 Assert rst while 3 results are in flight -> out_valid=0, Y=0, skip=0 next cycle; no stale result ever appears.
- REQ-034 With JCSA_OVF_EN: A=0x7FFF, B=0x0001, cin=0 -> Y=0x8000, overflow=1, carryout=0; A=0x8000, B=0x8000 -> Y=0x0000, overflow=1, carryout=1.
